// File: rtl/alu_mdu_if.sv
// ---------------------------------------------------------------------------
// alu_mdu_if
//
// Bundles the operand/request side and the result side of the execute-stage
// ALU + multiply/divide unit so the pipeline and the unit share one port.
//
// Signals:
//   SrcA, SrcB  operands (WIDTH bits)
//   ALUCtr      4-bit operation select
//   in_valid    operation request from the pipeline
//   in_ready    unit can accept an operation (low while MULTU/DIVU runs)
//   ALURes      registered result
//   Zero        ALURes == 0
//   Overflow    signed overflow of the last ADD/SUB, 0 otherwise
//   out_valid   one-cycle pulse when ALURes/Overflow carry a new result
//   Hi, Lo      HI/LO registers for debug and forwarding
//
// Modports:
//   master  the pipeline side (drives operands and requests)
//   slave   the alu_mdu side (drives results and in_ready)
// ---------------------------------------------------------------------------
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUCtr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ALURes;
    logic             Zero;
    logic             Overflow;
    logic             out_valid;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output SrcA, SrcB, ALUCtr, in_valid,
        input  in_ready, ALURes, Zero, Overflow, out_valid, Hi, Lo
    );

    modport slave (
        input  SrcA, SrcB, ALUCtr, in_valid,
        output in_ready, ALURes, Zero, Overflow, out_valid, Hi, Lo
    );
endinterface

// File: rtl/alu_mdu.sv
// ---------------------------------------------------------------------------
// alu_mdu
//
// Execute-stage unit for the pipelined MIPS core. Single-cycle ALU operations
// are computed combinationally and registered at the accept edge; MULTU and
// DIVU run iteratively (one bit per clock, WIDTH iterations) and write the
// HI/LO registers on their final iteration. While an iterative operation is
// in flight in_ready is low and new requests are ignored.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (clears results, HI/LO, aborts MDU)
//   bus   alu_mdu_if slave modport (operands, request, results, HI/LO)
//
// Operation encodings (ALUCtr):
//   0000 AND   0001 OR    0010 ADD   0011 XOR
//   0100 SLL   0101 SRL   0110 SUB   0111 SLTU
//   1000 SLT   1001 MULTU 1010 DIVU  1011 MFHI
//   1100 NOR   1101 MFLO  1110 MTHI  1111 MTLO
// ---------------------------------------------------------------------------
module alu_mdu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_mdu_if.slave bus
);

    // Counter holds WIDTH down to 1, so it needs one bit more than SHAMT_W.
    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_MFHI  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;
    localparam logic [3:0] OP_MTHI  = 4'b1110;
    localparam logic [3:0] OP_MTLO  = 4'b1111;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    // -----------------------------------------------------------------------
    // Signed overflow detection for the two's-complement add/subtract.
    // -----------------------------------------------------------------------
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_opnd;     // multiplicand or divisor, captured at accept
    logic [WIDTH-1:0] r_acc_hi;   // partial product high half / partial remainder
    logic [WIDTH-1:0] r_acc_lo;   // multiplier bits / dividend bits -> quotient
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_res;
    logic             r_ovf;
    logic             r_vld;

    // -----------------------------------------------------------------------
    // Single-cycle ALU datapath
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu;
    logic             w_alu_ovf;
    logic             w_is_mdu;
    logic             w_accept;

    assign w_sum    = bus.SrcA + bus.SrcB;
    assign w_diff   = bus.SrcA - bus.SrcB;
    assign w_is_mdu = (bus.ALUCtr == OP_MULTU) || (bus.ALUCtr == OP_DIVU);
    assign w_accept = bus.in_valid && (r_state == ST_IDLE);

    always_comb begin
        w_alu     = '0;
        w_alu_ovf = 1'b0;
        case (bus.ALUCtr)
            OP_AND:  w_alu = bus.SrcA & bus.SrcB;
            OP_OR:   w_alu = bus.SrcA | bus.SrcB;
            OP_XOR:  w_alu = bus.SrcA ^ bus.SrcB;
            OP_NOR:  w_alu = ~(bus.SrcA | bus.SrcB);
            OP_ADD: begin
                w_alu     = w_sum;
                w_alu_ovf = add_ovf(bus.SrcA[WIDTH-1], bus.SrcB[WIDTH-1],
                                    w_sum[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu     = w_diff;
                w_alu_ovf = sub_ovf(bus.SrcA[WIDTH-1], bus.SrcB[WIDTH-1],
                                    w_diff[WIDTH-1]);
            end
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}},
                              ($signed(bus.SrcA) < $signed(bus.SrcB))};
            OP_SLL:  w_alu = bus.SrcA << bus.SrcB[SHAMT_W-1:0];
            OP_SRL:  w_alu = bus.SrcA >> bus.SrcB[SHAMT_W-1:0];
            OP_MFHI: w_alu = r_hi;
            OP_MFLO: w_alu = r_lo;
            OP_MTHI: w_alu = bus.SrcA;
            OP_MTLO: w_alu = bus.SrcA;
            default: w_alu = '0;   // MULTU/DIVU: result comes from the MDU
        endcase
    end

    // -----------------------------------------------------------------------
    // Multiply iteration: add the multiplicand when the current multiplier
    // bit is set, then shift {carry, acc_hi, acc_lo} right by one. After WIDTH
    // steps {acc_hi, acc_lo} is the full product.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;

    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

    // -----------------------------------------------------------------------
    // Restoring divide iteration: shift the next dividend bit into the
    // partial remainder, subtract the divisor when it fits and shift the
    // quotient bit in at the bottom of acc_lo. The shifted remainder is
    // always below twice the divisor, so WIDTH+1 bits hold it and the
    // difference, when taken, fits in WIDTH bits. A zero divisor always
    // "fits", which yields an all-ones quotient and a remainder equal to
    // the dividend without any special casing.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   w_shifted;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_div_diff;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    assign w_shifted  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ok   = (w_shifted >= {1'b0, r_opnd});
    assign w_div_diff = w_shifted[WIDTH-1:0] - r_opnd;
    assign w_div_hi   = w_div_ok ? w_div_diff : w_shifted[WIDTH-1:0];
    assign w_div_lo   = {r_acc_lo[WIDTH-2:0], w_div_ok};

    logic [WIDTH-1:0] w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;

    assign w_nxt_hi = r_is_div ? w_div_hi : w_mul_hi;
    assign w_nxt_lo = r_is_div ? w_div_lo : w_mul_lo;

    // -----------------------------------------------------------------------
    // Control FSM and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_opnd   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
            r_vld    <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mdu) begin
                            r_state  <= ST_BUSY;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_is_div <= (bus.ALUCtr == OP_DIVU);
                            r_opnd   <= bus.SrcB;
                            r_acc_hi <= '0;
                            r_acc_lo <= bus.SrcA;
                        end else begin
                            r_res <= w_alu;
                            r_ovf <= w_alu_ovf;
                            r_vld <= 1'b1;
                            if (bus.ALUCtr == OP_MTHI) r_hi <= bus.SrcA;
                            if (bus.ALUCtr == OP_MTLO) r_lo <= bus.SrcA;
                        end
                    end
                end
                ST_BUSY: begin
                    r_acc_hi <= w_nxt_hi;
                    r_acc_lo <= w_nxt_lo;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    // Final iteration: HI/LO only change here, never mid-run.
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= w_nxt_hi;
                        r_lo    <= w_nxt_lo;
                        r_res   <= w_nxt_lo;
                        r_ovf   <= 1'b0;
                        r_vld   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.ALURes    = r_res;
    assign bus.Zero      = (r_res == '0);
    assign bus.Overflow  = r_ovf;
    assign bus.out_valid = r_vld;
    assign bus.Hi        = r_hi;
    assign bus.Lo        = r_lo;

endmodule
